// File: rtl/bitreversal_if.sv
// Control/data bundle between the bit-reversal register block (master) and
// the permutation engine (slave). Signal names match the register block's ports.
interface bitreversal_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              read_i;
  logic              write_i;
  logic [DATA_W-1:0] din_i;
  logic              done_o;
  logic [DATA_W-1:0] dout_o;

  modport master (output start_i, read_i, write_i, din_i, input  done_o, dout_o);
  modport slave  (input  start_i, read_i, write_i, din_i, output done_o, dout_o);
endinterface

// File: rtl/bitreversal_core.sv
// Bit-reversal permutation engine: buffers an N-word frame, reorders it in
// place into bit-reversed index order, then pops it out word by word.
module bitreversal_core #(
  parameter int LOG2_N = 4,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bitreversal_if.slave   bus
);
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N:0] ONE  = (LOG2_N+1)'(1);
  localparam logic [LOG2_N:0] LAST = (LOG2_N+1)'(N-1);
  localparam logic [LOG2_N:0] FULL = (LOG2_N+1)'(N);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PERMUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]                   state;
  logic                         start_q, read_q, write_q;
  logic                         start_edge, read_edge, write_edge;
  logic [LOG2_N:0]              fill, idx, rd_ptr;
  logic [N-1:0][DATA_W-1:0]     mem;
  logic [LOG2_N-1:0]            idx_lo, rev;
  logic                         done_q;
  logic [DATA_W-1:0]            dout_q;

  // Control registers are sticky levels, so only rising edges act.
  assign start_edge = bus.start_i & ~start_q;
  assign read_edge  = bus.read_i  & ~read_q;
  assign write_edge = bus.write_i & ~write_q;

  assign idx_lo = idx[LOG2_N-1:0];
  for (genvar g = 0; g < LOG2_N; g++) begin : g_rev
    assign rev[g] = idx_lo[LOG2_N-1-g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      start_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      fill    <= '0;
      idx     <= '0;
      rd_ptr  <= '0;
      mem     <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      start_q <= bus.start_i;
      read_q  <= bus.read_i;
      write_q <= bus.write_i;
      case (state)
        IDLE: begin
          // A write and start in the same cycle both take effect; the
          // permutation then sees the freshly stored word.
          if (write_edge && fill < FULL) begin
            mem[fill[LOG2_N-1:0]] <= bus.din_i;
            fill                  <= fill + ONE;
          end
          if (start_edge) begin
            state <= PERMUTE;
            idx   <= '0;
          end
        end
        PERMUTE: begin
          // Swap only from the lower index so each pair is exchanged once.
          if (idx_lo < rev) begin
            mem[idx_lo] <= mem[rev];
            mem[rev]    <= mem[idx_lo];
          end
          idx <= idx + ONE;
          if (idx == LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            rd_ptr <= '0;
          end
        end
        DONE: begin
          if (read_edge) begin
            dout_q <= mem[rd_ptr[LOG2_N-1:0]];
            rd_ptr <= rd_ptr + ONE;
            if (rd_ptr == LAST) begin
              state  <= IDLE;
              done_q <= 1'b0;
              fill   <= '0;
              mem    <= '0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done_o = done_q;
  assign bus.dout_o = dout_q;
endmodule

// File: doc/bitreversal_core.md
# bitreversal_core

Bit-reversal permutation engine placed directly downstream of the bit-reversal control-register block. It takes that block's sticky `start`/`read`/`write` levels and `din` word, buffers an N-word frame, and reorders it in place into bit-reversed index order. It then returns the reordered words one at a time on `dout_o` and reports completion on `done_o`. Typical use is the input reordering stage of a radix-2 FFT.

## Interface
Parameters:
- `LOG2_N`, default 4: frame length N = 2^LOG2_N words; legal range 1..8.
- `DATA_W`, default 32: word width; must match the register file `din`/`dout` width.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  level from the SW register; the rising edge starts the permutation.
- `read_i`  in  1  level from the SW register; the rising edge pops one output word.
- `write_i`  in  1  level from the SW register; the rising edge pushes `din_i`.
- `din_i`  in  DATA_W  input word, sampled on the `write_i` edge.
- `done_o`  out  1  high while the permuted frame is available for readout.
- `dout_o`  out  DATA_W  last popped word; held until the next pop.

## Operation
- **Edge detection.** The control registers are sticky, so every control input is edge-detected.
  - Each control input has a previous-value flop, reset to 0.
  - `x_edge = x_i & ~x_q`.
  - A level held high produces exactly one edge.
  - A level that is already high when reset releases produces an edge in the first post-reset cycle.
- **Storage.** N×DATA_W register array `mem`, cleared to 0 on reset and on every return to IDLE. Counters:
  - `fill` (0..N)
  - `idx` (LOG2_N+1 bits)
  - `rd_ptr` (LOG2_N+1 bits)
- **FSM: IDLE, PERMUTE, DONE.** Reset state is IDLE.
- **IDLE:**
  - `write_edge` with `fill < N`: `mem[fill] <= din_i`, `fill++`.
  - `write_edge` with `fill == N`: ignored. No wrap, no overwrite.
  - `start_edge`: go to PERMUTE with `idx <= 0`. Accepted for any `fill`, including 0; unloaded entries stay 0.
  - `write_edge` and `start_edge` in the same cycle: the write is stored and the start is accepted. The permutation sees the new word.
  - `read_edge`: ignored.
- **PERMUTE:** one index per cycle.
  - `r = bitrev(idx[LOG2_N-1:0])`.
  - If `idx < r`, swap `mem[idx]` and `mem[r]` in the same cycle. Otherwise no change.
  - `idx++`. After processing `idx = N-1`, go to DONE with `rd_ptr <= 0`.
  - All control edges are ignored.
- **DONE:**
  - `read_edge`: `dout_o <= mem[rd_ptr]`, `rd_ptr++`.
  - On the pop with `rd_ptr == N-1`: go to IDLE, `fill <= 0`, clear `mem`.
  - `start_edge` and `write_edge`: ignored.
- **Outputs.**
  - `done_o` is registered, equal to `state == DONE`.
  - `dout_o` is registered; it is not cleared when returning to IDLE.
- **Arithmetic.**
  - `bitrev` mirrors bits `[LOG2_N-1:0]`; it is pure wiring.
  - Counters never exceed N; there is no modular wrap.
- **Reset mid-operation.** In any state, `rst_i` returns to IDLE in one cycle and discards the frame.

## Timing
- Reset values: `done_o = 0`, `dout_o = 0`, state IDLE, `fill = 0`, all edge flops 0, `mem` all 0.
- Write: edge seen in cycle t; the word is in `mem` from t+1.
- Start: edge seen in cycle t.
  - PERMUTE occupies cycles t+1..t+N.
  - `done_o` rises in cycle t+N+1. Latency is N+1 cycles, independent of `fill`.
- Read: edge seen in cycle t; the new `dout_o` is valid from t+1.
  - After the Nth pop, `done_o` falls in t+1, together with the final `dout_o` update.
- Throughput: at most one pop or push per control-level rising edge. Software must drop and re-raise each level between operations.

## Test plan
- **Full frame, LOG2_N=4.**
  - Stimulus: push 0..15, start, then pop 16 times.
  - Required: `done_o` rises exactly 17 cycles after the start edge.
  - Required pop sequence: 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Required: `done_o` falls the cycle after the 16th pop.
- **Partial frame.**
  - Stimulus: push 0xA, 0xB, 0xC; start; pop 16 times.
  - Required: pop 0 = 0xA, pop 8 = 0xB, pop 4 = 0xC; all other pops = 0.
- **Overflow and ignored edges.**
  - Stimulus: push 17 words 100..116; start; pop 16 times.
  - Required: word 116 is absent from the output.
  - Stimulus: read edges in IDLE and PERMUTE.
  - Required: `dout_o` unchanged.
  - Stimulus: start and write edges in DONE.
  - Required: no effect.
- **Sticky levels.**
  - Stimulus: `start_i` held high 200 cycles, then `read_i` held high 50 cycles.
  - Required: exactly one permutation and exactly one pop (`dout_o` = element 0); `done_o` stays 1.
- **Reset during PERMUTE.**
  - Stimulus: assert `rst_i` at cycle t+5 after a start edge.
  - Required: `done_o = 0` and `dout_o = 0` next cycle.
  - Follow-up: a full reload of 0..15 then reproduces the first scenario's output.
- **Back-to-back frames.**
  - Stimulus: a second full load/start/pop with data 16..31 immediately after the first frame drains.
  - Required: the bit-reversed order of 16..31, with no residue from frame 1.
